// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle for bin2bcd_seq: start/value request, ready/done
// status and the BCD digits plus sign flag for a seven-segment decoder.
interface bin2bcd_seq_if;
  logic       start;
  logic [7:0] value;
  logic       ready;
  logic       done;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       neg;

  modport master (
    output start,
    output value,
    input  ready,
    input  done,
    input  hundreds,
    input  tens,
    input  ones,
    input  neg
  );

  modport slave (
    input  start,
    input  value,
    output ready,
    output done,
    output hundreds,
    output tens,
    output ones,
    output neg
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3), one
// conversion per 9 clocks, with optional two's-complement sign handling.
module bin2bcd_seq #(
  parameter bit SIGNED = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  bin2bcd_seq_if.slave  bus
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t      state, state_d;
  logic [7:0]  mag, mag_d;
  logic        sign, sign_d;
  logic [11:0] bcd, bcd_d;
  logic [3:0]  cnt, cnt_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic        neg_q, neg_d;
  logic        done_q, done_d;

  logic        neg_in;
  logic [7:0]  mag_in;
  logic [11:0] bcd_adj;
  logic [19:0] sh;

  function automatic logic [3:0] adj3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Magnitude fits in 8 unsigned bits: negating 8'h80 yields 8'h80 = 128.
  always_comb begin
    neg_in = SIGNED && bus.value[7];
    mag_in = neg_in ? (~bus.value + 8'd1) : bus.value;
  end

  always_comb begin
    bcd_adj = {adj3(bcd[11:8]), adj3(bcd[7:4]), adj3(bcd[3:0])};
    sh      = {bcd_adj, mag} << 1;
  end

  always_comb begin
    state_d = state;
    mag_d   = mag;
    sign_d  = sign;
    bcd_d   = bcd;
    cnt_d   = cnt;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    neg_d   = neg_q;
    done_d  = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          mag_d   = mag_in;
          sign_d  = neg_in;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = sh[19:8];
        mag_d = sh[7:0];
        cnt_d = cnt + 4'd1;
        if (cnt == 4'd7) begin
          hund_d  = sh[19:16];
          tens_d  = sh[15:12];
          ones_d  = sh[11:8];
          neg_d   = sign;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mag    <= '0;
      sign   <= 1'b0;
      bcd    <= '0;
      cnt    <= '0;
      hund_q <= '0;
      tens_q <= '0;
      ones_q <= '0;
      neg_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      mag    <= mag_d;
      sign   <= sign_d;
      bcd    <= bcd_d;
      cnt    <= cnt_d;
      hund_q <= hund_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
      neg_q  <= neg_d;
      done_q <= done_d;
    end
  end

  assign bus.ready    = (state == IDLE);
  assign bus.done     = done_q;
  assign bus.hundreds = hund_q;
  assign bus.tens     = tens_q;
  assign bus.ones     = ones_q;
  assign bus.neg      = neg_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: signed and unsigned instances driven in
// lockstep, hand-computed vectors followed by a full 256-value sweep.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bin2bcd_seq_if ia ();
  bin2bcd_seq_if ib ();

  bin2bcd_seq #(.SIGNED(1'b1)) dut_s (.clk(clk), .reset(reset), .bus(ia));
  bin2bcd_seq #(.SIGNED(1'b0)) dut_u (.clk(clk), .reset(reset), .bus(ib));

  int checks = 0;
  int errors = 0;
  logic [12:0] prev_s, prev_u;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] outs_s();
    return {ia.hundreds, ia.tens, ia.ones, ia.neg};
  endfunction

  function automatic logic [12:0] outs_u();
    return {ib.hundreds, ib.tens, ib.ones, ib.neg};
  endfunction

  // Reference: decimal digits of |v| by division, sign only in signed mode.
  function automatic logic [12:0] model(input logic [7:0] v, input bit sgn);
    int m;
    bit n;
    n = sgn && v[7];
    m = n ? 256 - int'(v) : int'(v);
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10), n};
  endfunction

  function automatic logic in_range(input logic [12:0] o);
    return (o[12:9] <= 4'd2) && (o[8:5] <= 4'd9) && (o[4:1] <= 4'd9);
  endfunction

  task automatic set_in(input logic st, input logic [7:0] v);
    ia.start = st; ia.value = v;
    ib.start = st; ib.value = v;
  endtask

  task automatic run_conv(input string tag, input logic [7:0] v,
                          input logic [12:0] es, input logic [12:0] eu);
    int seen;
    set_in(1'b1, v);
    tick();
    set_in(1'b0, ~v);
    chk({tag, " busy"}, {30'd0, ia.ready, ib.ready}, 32'd0);
    chk({tag, " hold_s"}, 32'(outs_s()), 32'(prev_s));
    chk({tag, " hold_u"}, 32'(outs_u()), 32'(prev_u));
    seen = 0;
    for (int i = 1; i < 8; i++) begin
      if (i == 3) set_in(1'b1, v + 8'd1);
      if (i == 5) set_in(1'b0, ~v);
      tick();
      if (ia.done || ib.done) seen++;
    end
    chk({tag, " early_done"}, seen, 0);
    tick();
    chk({tag, " done"}, {30'd0, ia.done, ib.done}, 32'd3);
    chk({tag, " ready"}, {30'd0, ia.ready, ib.ready}, 32'd3);
    chk({tag, " digits_s"}, 32'(outs_s()), 32'(es));
    chk({tag, " digits_u"}, 32'(outs_u()), 32'(eu));
    chk({tag, " range"}, {30'd0, in_range(outs_s()), in_range(outs_u())}, 32'd3);
    tick();
    chk({tag, " pulse"}, {30'd0, ia.done, ib.done}, 32'd0);
    prev_s = es;
    prev_u = eu;
  endtask

  initial begin
    int seen;
    logic [7:0] v;
    logic [7:0] acc;

    reset = 1'b1;
    set_in(1'b0, 8'h00);
    prev_s = '0;
    prev_u = '0;
    tick();
    tick();
    chk("rst ready", {30'd0, ia.ready, ib.ready}, 32'd3);
    chk("rst done", {30'd0, ia.done, ib.done}, 32'd0);
    chk("rst out_s", 32'(outs_s()), 32'd0);
    chk("rst out_u", 32'(outs_u()), 32'd0);

    // First start lands on the first edge with reset low.
    reset = 1'b0;
    run_conv("v7F", 8'h7F, {4'd1, 4'd2, 4'd7, 1'b0}, {4'd1, 4'd2, 4'd7, 1'b0});
    run_conv("v80", 8'h80, {4'd1, 4'd2, 4'd8, 1'b1}, {4'd1, 4'd2, 4'd8, 1'b0});
    run_conv("vFF", 8'hFF, {4'd0, 4'd0, 4'd1, 1'b1}, {4'd2, 4'd5, 4'd5, 1'b0});
    run_conv("v00", 8'h00, {4'd0, 4'd0, 4'd0, 1'b0}, {4'd0, 4'd0, 4'd0, 1'b0});
    run_conv("v01", 8'h01, {4'd0, 4'd0, 4'd1, 1'b0}, {4'd0, 4'd0, 4'd1, 1'b0});
    run_conv("v9C", 8'h9C, {4'd1, 4'd0, 4'd0, 1'b1}, {4'd1, 4'd5, 4'd6, 1'b0});
    run_conv("v64", 8'h64, {4'd1, 4'd0, 4'd0, 1'b0}, {4'd1, 4'd0, 4'd0, 1'b0});

    // Back-to-back: start held high, value stepping every cycle.
    for (int cyc = 0; cyc < 27; cyc++) begin
      v = 8'(cyc * 37 + 5);
      set_in(1'b1, v);
      tick();
      if (cyc % 9 == 8) begin
        acc = 8'((cyc - 8) * 37 + 5);
        chk($sformatf("b2b%0d done", cyc), {30'd0, ia.done, ib.done}, 32'd3);
        chk($sformatf("b2b%0d ready", cyc), {30'd0, ia.ready, ib.ready}, 32'd3);
        chk($sformatf("b2b%0d dig_s", cyc), 32'(outs_s()), 32'(model(acc, 1'b1)));
        chk($sformatf("b2b%0d dig_u", cyc), 32'(outs_u()), 32'(model(acc, 1'b0)));
      end else begin
        chk($sformatf("b2b%0d idle", cyc), {28'd0, ia.done, ib.done, ia.ready, ib.ready}, 32'd0);
      end
    end
    set_in(1'b0, 8'h00);
    prev_s = model(8'(18 * 37 + 5), 1'b1);
    prev_u = model(8'(18 * 37 + 5), 1'b0);

    // Reset sampled at E4 aborts the conversion and zeroes the result.
    set_in(1'b1, 8'h7F);
    tick();
    set_in(1'b0, 8'h00);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort ready", {30'd0, ia.ready, ib.ready}, 32'd3);
    chk("abort done", {30'd0, ia.done, ib.done}, 32'd0);
    chk("abort out_s", 32'(outs_s()), 32'd0);
    chk("abort out_u", 32'(outs_u()), 32'd0);
    prev_s = '0;
    prev_u = '0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ia.done || ib.done) seen++;
    end
    chk("abort no_done", seen, 0);
    run_conv("post_rst", 8'hD6, {4'd0, 4'd4, 4'd2, 1'b1}, {4'd2, 4'd1, 4'd4, 1'b0});

    for (int i = 0; i < 256; i++) begin
      run_conv($sformatf("sweep%0d", i), 8'(i), model(8'(i), 1'b1), model(8'(i), 1'b0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter SIGNED, default 1: when 1, value is two's complement; when 0, value is unsigned.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a conversion of value; sampled only when ready=1.
REQ-005 value  input  8  binary operand (e.g. ALU result), sampled with start.
REQ-006 ready  output  1  high when idle and able to accept start.
REQ-007 done  output  1  single-cycle pulse: new result present on digit outputs.
REQ-008 hundreds  output  4  BCD hundreds digit of |value|.
REQ-009 tens  output  4  BCD tens digit of |value|.
REQ-010 ones  output  4  BCD ones digit of |value|.
REQ-011 neg  output  1  sign flag for the downstream seven-segment decoder's minus-sign input.
REQ-012 Clock is clk; reset is synchronous and active-high.

Function
REQ-013 Two states: IDLE, SHIFT; ready=1 exactly in IDLE.
REQ-014 IDLE, start=1 at edge E0: latch magnitude and sign, clear scratch BCD to 0, load iteration count 0, enter SHIFT.
REQ-015 Magnitude: SIGNED=1 and value[7]=1 -> 9-bit-safe negation (-128 -> 128); otherwise value unchanged.
REQ-016 Sign: SIGNED=1 -> value[7]; SIGNED=0 -> 0.
REQ-017 SHIFT, each edge: any scratch BCD nibble >=5 gets +3, then {BCD,magnitude} shift left 1; count increments.
REQ-018 Exactly 8 SHIFT iterations (edges E1..E8); at E8 update hundreds/tens/ones/neg from scratch and latched sign, set done=1, return to IDLE.
REQ-019 Latency: done high in the cycle after E8, i.e. 9 edges after start is sampled; ready returns high in the same cycle.
REQ-020 done is high for exactly one cycle per accepted start.
REQ-021 start while in SHIFT is ignored; value changes during SHIFT have no effect.
REQ-022 start=1 in the done cycle is accepted (back-to-back; one conversion per 9 cycles).
REQ-023 Digit outputs and neg hold the last completed result until the next E8; not cleared on start.
REQ-024 hundreds never exceeds 2; each digit always in 0..9.
REQ-025 neg=1 only with nonzero magnitude; value 0 always gives neg=0.

Reset
REQ-026 reset=1 at an edge: state IDLE, ready=1, done=0, hundreds=tens=ones=0, neg=0, count and scratch cleared.
REQ-027 reset has priority over start and over SHIFT progress; mid-conversion reset aborts with no done pulse and the previous result discarded (outputs zeroed).
REQ-028 The first start is accepted at the first edge with reset=0.

Verification
REQ-029 SIGNED=1, value=8'h7F, start 1 cycle -> after 9 edges done=1, hundreds/tens/ones=1/2/7, neg=0, ready=1.
REQ-030 SIGNED=1, value=8'h80 -> 1/2/8, neg=1; value=8'hFF -> 0/0/1, neg=1; value=8'h00 -> 0/0/0, neg=0.
REQ-031 SIGNED=0, value=8'hFF -> 2/5/5, neg=0; value=8'h80 -> 1/2/8, neg=0.
REQ-032 start held high continuously with value stepping -> one done every 9 cycles, each result matching value sampled at its acceptance edge; starts during SHIFT ignored.
REQ-033 Reset asserted at E4 of a conversion -> no done, outputs 0/0/0 neg=0, ready=1 the following cycle; next start converts normally.
REQ-034 Exhaustive sweep of all 256 values for both SIGNED settings against a reference model, checking done pulse width and digit range.
